// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and multi-cycle scheduler for the 5-stage pipeline.
//   - Detects load-use hazards between the instruction in decode and the
//     instruction in ID/EX, and inserts one bubble.
//   - Sequences the shared multiply/divide unit while an M instruction
//     occupies EX (IDLE -> BUSY -> DONE -> IDLE).
//   - Squashes IF/ID on a taken branch or jump resolved in EX.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   rs1_IF, rs2_IF, is_rs*_used     sources of the decoding instruction
//   rd_EX, rf_wr_en_EX, dm_rd_ctrl_EX, m_sel_EX, m_div_EX, jump_EX
//                                   fields of the instruction in ID/EX
//   stall_IF/ID/EX, flush_IF/ID     pipeline holds and squashes
//   m_start, m_valid, m_busy        M-unit handshake
//   stall_count                     saturating count of stall_IF cycles
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_IF,
  input  logic [4:0]  rs2_IF,
  input  logic        is_rs1_used,
  input  logic        is_rs2_used,
  input  logic [4:0]  rd_EX,
  input  logic        rf_wr_en_EX,
  input  logic [2:0]  dm_rd_ctrl_EX,
  input  logic        m_sel_EX,
  input  logic        m_div_EX,
  input  logic        jump_EX,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        flush_IF,
  output logic        flush_ID,
  output logic        m_start,
  output logic        m_valid,
  output logic        m_busy,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The START cycle is spent in IDLE, so BUSY needs LAT-1 cycles:
  // counting down from LAT-2 to 0 inclusive.
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 2);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 2);

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] stall_count_reg;
  logic        lu;

  assign lu = (dm_rd_ctrl_EX != 3'd0) && rf_wr_en_EX && (rd_EX != 5'd0) &&
              ((is_rs1_used && (rs1_IF == rd_EX)) ||
               (is_rs2_used && (rs2_IF == rd_EX)));

  // Outputs are combinational from state and inputs; gating with reset
  // forces them low for the whole time reset is held.
  always_comb begin
    stall_IF = 1'b0;
    stall_ID = 1'b0;
    stall_EX = 1'b0;
    flush_IF = 1'b0;
    flush_ID = 1'b0;
    m_start  = 1'b0;
    m_valid  = 1'b0;
    m_busy   = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (m_sel_EX) begin
            m_start  = 1'b1;
            m_busy   = 1'b1;
            stall_IF = 1'b1;
            stall_ID = 1'b1;
            stall_EX = 1'b1;
          end else if (jump_EX) begin
            // A concurrent load-use is moot: the consumer is squashed.
            flush_IF = 1'b1;
            flush_ID = 1'b1;
          end else if (lu) begin
            // Hold IF, bubble into ID/EX; the load moves on to MEM.
            stall_IF = 1'b1;
            flush_ID = 1'b1;
          end
        end
        BUSY: begin
          stall_IF = 1'b1;
          stall_ID = 1'b1;
          stall_EX = 1'b1;
          m_busy   = 1'b1;
        end
        DONE: begin
          m_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m_sel_EX) begin
            cnt_reg   <= m_div_EX ? DIV_CNT : MUL_CNT;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg == 6'd0) state_reg <= DONE;
          else                 cnt_reg   <= cnt_reg - 6'd1;
        end
        // m_sel_EX is still high in DONE for the finishing instruction;
        // ignoring it prevents a spurious restart.
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= 32'd0;
    end else if (stall_IF && (stall_count_reg != 32'hFFFF_FFFF)) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_IF, rs2_IF, rd_EX;
  logic        is_rs1_used, is_rs2_used, rf_wr_en_EX;
  logic [2:0]  dm_rd_ctrl_EX;
  logic        m_sel_EX, m_div_EX, jump_EX;
  logic        stall_IF, stall_ID, stall_EX, flush_IF, flush_ID;
  logic        m_start, m_valid, m_busy;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  // Output vector order: {stall_IF, stall_ID, stall_EX, flush_IF, flush_ID, m_start, m_valid, m_busy}
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1000_1000;
  localparam logic [7:0] O_JMP   = 8'b0001_1000;
  localparam logic [7:0] O_START = 8'b1110_0101;
  localparam logic [7:0] O_BUSY  = 8'b1110_0001;
  localparam logic [7:0] O_DONE  = 8'b0000_0010;

  pipeline_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk(clk), .reset(reset),
    .rs1_IF(rs1_IF), .rs2_IF(rs2_IF),
    .is_rs1_used(is_rs1_used), .is_rs2_used(is_rs2_used),
    .rd_EX(rd_EX), .rf_wr_en_EX(rf_wr_en_EX), .dm_rd_ctrl_EX(dm_rd_ctrl_EX),
    .m_sel_EX(m_sel_EX), .m_div_EX(m_div_EX), .jump_EX(jump_EX),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
    .flush_IF(flush_IF), .flush_ID(flush_ID),
    .m_start(m_start), .m_valid(m_valid), .m_busy(m_busy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wr, jmp;
    logic [2:0] dm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [7:0] outs();
    return {stall_IF, stall_ID, stall_EX, flush_IF, flush_ID, m_start, m_valid, m_busy};
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    checks++;
    if (stall_count !== 32'(exp_count)) begin
      errors++;
      $display("FAIL %s: stall_count got %0d expected %0d", name, stall_count, exp_count);
    end
  endtask

  task automatic clear_inputs();
    rs1_IF = 0; rs2_IF = 0; rd_EX = 0; is_rs1_used = 0; is_rs2_used = 0;
    rf_wr_en_EX = 0; dm_rd_ctrl_EX = 0; m_sel_EX = 0; m_div_EX = 0; jump_EX = 0;
  endtask

  // Holds an M instruction in EX for its full occupancy (LAT+1 cycles).
  task automatic run_m(input logic div, input int lat, input string tag);
    logic [7:0] e;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      clear_inputs();
      m_sel_EX = 1'b1;
      m_div_EX = div;
      #1;
      e = (c == 0) ? O_START : (c < lat) ? O_BUSY : O_DONE;
      chk8($sformatf("%s_cyc%0d", tag, c), outs(), e);
      $display("%s cycle %0d outs=%b", tag, c, outs());
    end
    exp_count += lat;
  endtask

  initial begin
    // rs1  rs2  rd  u1 u2 wr jmp dm      expected
    vecs[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, O_NONE};
    vecs[1] = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, O_LU};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, O_NONE};
    vecs[3] = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, O_NONE};
    vecs[4] = '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100, O_LU};
    vecs[5] = '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, O_NONE};
    vecs[6] = '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, O_NONE};
    vecs[7] = '{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, O_JMP};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, O_JMP};
    vecs[9] = '{5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, O_NONE};

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    // Inputs forming a load-use must not leak out while reset is held.
    rs2_IF = 5; rd_EX = 5; is_rs2_used = 1; rf_wr_en_EX = 1; dm_rd_ctrl_EX = 3'b010;
    #1;
    chk8("reset_hold_outs", outs(), O_NONE);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1;
    chk8("reset_release_outs", outs(), O_NONE);
    chk_cnt("reset_release_count");

    // Combinational IDLE behaviour.
    foreach (vecs[i]) begin
      @(negedge clk);
      rs1_IF = vecs[i].rs1; rs2_IF = vecs[i].rs2; rd_EX = vecs[i].rd;
      is_rs1_used = vecs[i].u1; is_rs2_used = vecs[i].u2;
      rf_wr_en_EX = vecs[i].wr; jump_EX = vecs[i].jmp; dm_rd_ctrl_EX = vecs[i].dm;
      m_sel_EX = 0; m_div_EX = 0;
      #1;
      chk8($sformatf("vec%0d", i), outs(), vecs[i].exp);
      $display("vec %0d outs=%b exp=%b", i, outs(), vecs[i].exp);
      exp_count += int'(vecs[i].exp[7]);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk_cnt("after_vectors_count");

    // Multiply alone.
    run_m(1'b0, 3, "mul");
    @(negedge clk);
    clear_inputs();
    #1;
    chk8("mul_then_idle", outs(), O_NONE);
    chk_cnt("mul_count");

    // Divide followed immediately by multiply.
    run_m(1'b1, 33, "div");
    run_m(1'b0, 3, "mul2");
    @(negedge clk);
    clear_inputs();
    #1;
    chk8("div_mul_then_idle", outs(), O_NONE);
    chk_cnt("div_mul_count");

    // Reset in the middle of a divide, away from any clock edge.
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      clear_inputs();
      m_sel_EX = 1; m_div_EX = 1;
      #1;
      chk8($sformatf("rst_div_cyc%0d", c), outs(), (c == 0) ? O_START : O_BUSY);
    end
    #1;
    reset = 1'b1;
    exp_count = 0;
    #1;
    chk8("mid_busy_reset_outs", outs(), O_NONE);
    chk_cnt("mid_busy_reset_count");
    $display("reset mid-busy outs=%b count=%0d", outs(), stall_count);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1;
    chk8("post_reset_outs", outs(), O_NONE);
    chk_cnt("post_reset_count");
    // A fresh START proves the FSM came back in IDLE with the short latency.
    run_m(1'b0, 3, "mul_after_reset");
    @(negedge clk);
    clear_inputs();
    #1;
    chk8("final_idle", outs(), O_NONE);
    chk_cnt("final_count");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and multi-cycle scheduler for the 5-stage pipeline. Sits beside the ID-control stage and drives that stage's `stall`/`flush` inputs, plus the IF and EX holds. It detects load-use hazards between the instruction being decoded and the instruction latched in ID/EX. It sequences the shared multiply/divide unit when an `m_sel` instruction reaches EX, and squashes IF/ID on a taken branch or jump resolved in EX.

## Interface
Parameters:
- `MUL_LAT`, default 3: EX occupancy, in stall cycles, of a multiply (`m_div_EX`=0); minimum 2.
- `DIV_LAT`, default 33: EX occupancy, in stall cycles, of a divide/remainder (`m_div_EX`=1); minimum 2.

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset. FSM goes to IDLE and the counters clear immediately; all outputs are 0 while it is asserted.
- `rs1_IF`, `rs2_IF`  in  5 each  source registers of the instruction currently being decoded (`instruction_IF[19:15]`, `[24:20]`).
- `is_rs1_used`, `is_rs2_used`  in  1 each  decoder flags for that instruction.
- `rd_EX`  in  5  destination register latched in ID/EX.
- `rf_wr_en_EX`  in  1  register-file write enable latched in ID/EX.
- `dm_rd_ctrl_EX`  in  3  load control latched in ID/EX; nonzero means the instruction is a load.
- `m_sel_EX`  in  1  ID/EX holds a multiply/divide instruction.
- `m_div_EX`  in  1  that instruction is div/divu/rem/remu.
- `jump_EX`  in  1  taken branch or jump resolved in EX this cycle.
- `stall_IF`  out  1  hold PC and the IF register.
- `stall_ID`  out  1  hold the ID-control stage (its `stall` input).
- `stall_EX`  out  1  hold the EX/MEM boundary; insert a bubble into MEM.
- `flush_IF`  out  1  squash the IF register.
- `flush_ID`  out  1  clear the ID-control stage (its `flush` input), inserting a bubble.
- `m_start`  out  1  one-cycle pulse: latch operands into the M unit.
- `m_valid`  out  1  M-unit result valid; EX forwards it this cycle.
- `m_busy`  out  1  FSM is in START or BUSY.
- `stall_count`  out  32  saturating count of cycles with `stall_IF`=1.

## Operation
FSM states are IDLE, BUSY and DONE. There is one down-counter `cnt`, 6 bits wide, sized for `DIV_LAT`.

Load-use detection (`lu`, combinational, evaluated only in IDLE):
- `lu` = `dm_rd_ctrl_EX`≠0 & `rf_wr_en_EX` & `rd_EX`≠0 & ((`is_rs1_used` & `rs1_IF`==`rd_EX`) | (`is_rs2_used` & `rs2_IF`==`rd_EX`)).

IDLE, priority top to bottom:
- `m_sel_EX`:
  - Assert `m_start`, `m_busy`, `stall_IF`, `stall_ID` and `stall_EX`.
  - Load `cnt` = LAT−2, where LAT is `DIV_LAT` if `m_div_EX` else `MUL_LAT`.
  - Next state BUSY.
  - `jump_EX` is ignored in this cycle; it is a protocol violation for it to accompany `m_sel_EX`.
- `jump_EX`: assert `flush_IF` and `flush_ID` for one cycle, with no stall. Any concurrent `lu` is discarded.
- `lu`: assert `stall_IF` and `flush_ID` for one cycle (one bubble). `stall_ID` stays 0.
- Otherwise all outputs are 0.

BUSY:
- Assert `stall_IF`, `stall_ID`, `stall_EX` and `m_busy`.
- If `cnt`==0, next state is DONE; otherwise decrement `cnt`.
- `jump_EX` and `lu` are ignored.

DONE:
- Assert `m_valid` for one cycle, with no stalls. The M instruction leaves EX at the end of this cycle.
- Next state is IDLE unconditionally.
- `m_sel_EX` is ignored in DONE, so the same instruction does not restart the unit.

`stall_count`:
- Increments by 1 each cycle `stall_IF`=1.
- Holds at 0xFFFF_FFFF.
- Cleared only by `reset`.

## Timing
- All outputs are combinational from state and inputs. State and `cnt` are registered.
- M instruction arriving in EX at cycle 0:
  - `stall_*` are high for cycles 0..LAT−1 (LAT cycles total).
  - `m_valid` is high in cycle LAT.
  - EX occupancy is LAT+1 cycles.
- Back-to-back M instructions: the second arrives in EX in the cycle after DONE and is seen in IDLE, giving a fresh START.
- Load-use costs exactly one bubble. In the next cycle the load is in MEM, so `lu` evaluates to 0.
- Reset asserted mid-BUSY: outputs drop to 0 asynchronously. After release, the FSM is in IDLE with `cnt`=0 and `stall_count`=0.

## Test plan
- Reset, then release with all inputs 0 → all outputs 0, `stall_count`=0, FSM in IDLE.
- `dm_rd_ctrl_EX`=3'b010, `rf_wr_en_EX`=1, `rd_EX`=5, `rs2_IF`=5, `is_rs2_used`=1 → one cycle of `stall_IF`=1, `flush_ID`=1, `stall_ID`=0; repeat with `rd_EX`=0 → no stall.
- `m_sel_EX`=1, `m_div_EX`=0, `MUL_LAT`=3 → `m_start` at cycle 0, stalls in cycles 0–2, `m_valid` in cycle 3, `stall_count`=3.
- Divide (`DIV_LAT`=33) followed immediately by a multiply → 33 stall cycles, `m_valid`, then a new `m_start` in the next cycle.
- `jump_EX`=1 together with a true `lu` condition → `flush_IF`=`flush_ID`=1, `stall_IF`=0, for one cycle.
- `reset` pulsed at BUSY cycle 10 of a divide → outputs 0 immediately; after release `m_busy`=0 and the FSM is in IDLE.
